stat_counter_ctrl: RTL
======================

STAT_COUNTER_CTRL -- requirements
Module: stat_counter_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, width of every statistics counter and of rd_data.
REQ-002 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: go  input  1  start/resume request, sampled each cycle.
REQ-005 Port: halt  input  1  CPU halt indication, level.
REQ-006 Port: ev_jmp  input  1  unconditional-jump retired strobe, one per cycle max.
REQ-007 Port: ev_br  input  1  conditional-branch retired strobe.
REQ-008 Port: ev_br_taken  input  1  qualifies ev_br as taken.
REQ-009 Port: clr_req  input  1  clear request, level, held until clr_ack seen.
REQ-010 Port: clr_ack  output  1  one-cycle clear acknowledge.
REQ-011 Port: sel  input  2  counter select: 0 cycles, 1 jumps, 2 branches, 3 taken branches.
REQ-012 Port: rd_data  output  WIDTH  registered value of selected counter.
REQ-013 Port: running  output  1  high exactly when FSM is in RUN.

Function
REQ-014 FSM states SHALL be IDLE, RUN, HALTED, CLEAR; encoding free.
REQ-015 IDLE: clr_req armed -> CLEAR; else go=1 and halt=0 -> RUN; else stay.
REQ-016 RUN: clr_req armed -> CLEAR; else halt=1 -> HALTED; else stay.
REQ-017 HALTED: clr_req armed -> CLEAR; else go=1 and halt=0 -> RUN; else stay.
REQ-018 CLEAR: lasts exactly one cycle, then IDLE unconditionally.
REQ-019 clr_req "armed" = clr_req high and an internal flag set; flag cleared on entering CLEAR, re-set when clr_req sampled low.
REQ-020 clr_ack SHALL be high only during the CLEAR cycle; exactly one pulse per armed request.
REQ-021 In CLEAR all four counters SHALL be written to 0 at the cycle's closing edge.
REQ-022 Counting only in RUN, including the cycle in which RUN is left for HALTED or CLEAR -> except CLEAR zeroing takes priority over that cycle's increments.
REQ-023 cnt_cycle +1 every RUN cycle.
REQ-024 cnt_jmp +1 per RUN cycle with ev_jmp=1.
REQ-025 cnt_br +1 per RUN cycle with ev_br=1.
REQ-026 cnt_taken +1 per RUN cycle with ev_br=1 and ev_br_taken=1; ev_br_taken alone ignored.
REQ-027 Counters SHALL wrap modulo 2^WIDTH (all-ones +1 -> 0); no saturation, no overflow flag.
REQ-028 Counters SHALL hold value in IDLE and HALTED; HALTED->RUN accumulates onto held values.
REQ-029 rd_data SHALL equal the counter selected by sel at the previous edge, post-update (1-cycle latency).
REQ-030 Events in IDLE, HALTED, CLEAR SHALL be ignored.

Reset
REQ-031 rst=0 SHALL immediately force state IDLE, all counters 0, rd_data 0, clr_ack 0, running 0, clear flag set (armed).
REQ-032 Reset mid-RUN SHALL discard the in-progress count; no increment on the deassertion edge.
REQ-033 After rst rises, first state change SHALL occur on the next rising clk edge.

Verification
REQ-034 Reset, go=1 one cycle, 10 RUN cycles, halt=1 -> running drops; sel=0 reads 11 (10 + halt cycle).
REQ-035 RUN with ev_br=1 for 5 cycles, ev_br_taken=1 on 2 of them, ev_br_taken=1 alone once -> sel=2 reads 5, sel=3 reads 2.
REQ-036 Force cnt_cycle to all-ones via long RUN (WIDTH=8 build), one more RUN cycle -> reads 0.
REQ-037 clr_req held high 5 cycles in RUN -> one clr_ack pulse, all counters 0, state IDLE, no second ack until clr_req low then high.
REQ-038 HALTED with cnt_cycle=20, go=1, 3 RUN cycles, halt -> reads 24; events during HALTED not counted.
REQ-039 Assert rst low mid-RUN asynchronously between edges -> running and rd_data 0 before next edge.

Source files
------------

// File: rtl/stat_counter_ctrl.sv
// Run-control FSM with four wrapping statistics counters (cycles, jumps, branches, taken branches).
// rd_data is registered, one cycle after sel; no backpressure, events outside RUN are dropped.
module stat_counter_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             halt,
  input  logic             ev_jmp,
  input  logic             ev_br,
  input  logic             ev_br_taken,
  input  logic             clr_req,
  output logic             clr_ack,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             running
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             arm_q, arm_d;
  logic             clr_armed;
  logic             zero_all;
  logic [WIDTH-1:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] jmp_q, jmp_d;
  logic [WIDTH-1:0] br_q, br_d;
  logic [WIDTH-1:0] tkn_q, tkn_d;
  logic [WIDTH-1:0] rd_q, rd_d;

  assign clr_armed = clr_req & arm_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (clr_armed)          state_d = ST_CLEAR;
        else if (go && !halt)   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clr_armed)          state_d = ST_CLEAR;
        else if (halt)          state_d = ST_HALTED;
      end
      default:                  state_d = ST_IDLE;
    endcase
  end

  // One ack per request: disarm on entering CLEAR, rearm only once clr_req is seen low.
  always_comb begin
    arm_d = arm_q;
    if (state_d == ST_CLEAR) arm_d = 1'b0;
    else if (!clr_req)       arm_d = 1'b1;
  end

  // Leaving RUN for CLEAR drops that cycle's increments so counters read zero throughout CLEAR.
  assign zero_all = (state_q == ST_CLEAR) || ((state_q == ST_RUN) && (state_d == ST_CLEAR));

  always_comb begin
    cyc_d = cyc_q;
    jmp_d = jmp_q;
    br_d  = br_q;
    tkn_d = tkn_q;
    if (zero_all) begin
      cyc_d = '0;
      jmp_d = '0;
      br_d  = '0;
      tkn_d = '0;
    end else if (state_q == ST_RUN) begin
      cyc_d = cyc_q + WIDTH'(1);
      jmp_d = jmp_q + WIDTH'(ev_jmp);
      br_d  = br_q  + WIDTH'(ev_br);
      tkn_d = tkn_q + WIDTH'(ev_br & ev_br_taken);
    end
  end

  always_comb begin
    rd_d = cyc_d;
    case (sel)
      2'd1:    rd_d = jmp_d;
      2'd2:    rd_d = br_d;
      2'd3:    rd_d = tkn_d;
      default: rd_d = cyc_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      arm_q   <= 1'b1;
      cyc_q   <= '0;
      jmp_q   <= '0;
      br_q    <= '0;
      tkn_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      cyc_q   <= cyc_d;
      jmp_q   <= jmp_d;
      br_q    <= br_d;
      tkn_q   <= tkn_d;
      rd_q    <= rd_d;
    end
  end

  assign clr_ack = (state_q == ST_CLEAR);
  assign running = (state_q == ST_RUN);
  assign rd_data = rd_q;

endmodule
